param_mux_scanner: RTL

Parametrised, registered N-to-1 multiplexer for the datapath lab. It selects one WIDTH-bit channel out of CHANNELS and presents it on a registered output. It has two modes: direct select, and auto-scan, where an internal pointer steps through every channel in turn. It feeds shared single-channel consumers (display, serial link, ALU operand bus) from several sources.

---
 rtl/param_mux_scanner.sv | 96 +++++++++
 1 files changed

// File: rtl/param_mux_scanner.sv
// Registered N-to-1 channel mux with direct-select and auto-scan modes; 1-cycle latency.
// No backpressure: en=0 freezes data/pointer and drops out_valid for that cycle.
module param_mux_scanner #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic                      en,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      load,
   output logic [WIDTH-1:0]          out,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   output logic                      wrap
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH-1:0] sel_dat;
   logic [WIDTH-1:0] ptr_dat;
   logic             sel_legal;

   // Legality falls out of the decode: an index matching no channel is illegal.
   always_comb begin
      sel_dat   = '0;
      ptr_dat   = '0;
      sel_legal = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_dat   = data_in[i*WIDTH +: WIDTH];
            sel_legal = 1'b1;
         end
         if (ptr_q == SEL_W'(i)) begin
            ptr_dat = data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      out_d       = out_q;
      out_ch_d    = out_ch_q;
      out_valid_d = 1'b0;
      wrap_d      = 1'b0;
      if (en) begin
         if (!mode) begin
            if (sel_legal) begin
               out_d       = sel_dat;
               out_ch_d    = sel;
               out_valid_d = 1'b1;
            end
         end else if (load) begin
            ptr_d = sel_legal ? sel : '0;
         end else begin
            out_d       = ptr_dat;
            out_ch_d    = ptr_q;
            out_valid_d = 1'b1;
            wrap_d      = (ptr_q == LAST_CH);
            // Wrap at the last real channel, not at the pointer's natural rollover.
            ptr_d       = (ptr_q == LAST_CH) ? '0 : ptr_q + SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= '0;
         out_q       <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         out_q       <= out_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         wrap_q      <= wrap_d;
      end
   end

   assign out       = out_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign wrap      = wrap_q;

endmodule
